// File: rtl/ps2_key_mapper.sv
// ps2_key_mapper: PS/2 keyboard receiver with held-key tracking.
// Conditions kb_clock/kb_data, frames 11-bit PS/2 packets and decodes
// make/break/extended scan codes into a per-key level vector.
//
// Output handshake: code_valid and frame_err are single-cycle,
// mutually exclusive strobes with no ready. scan_code is valid in any
// cycle where code_valid is high, and it holds that value until the
// next good frame. mapped_key is a level vector. It updates on the clk
// edge that follows the code_valid cycle.
// dbg_state and dbg_bit_cnt expose the receive FSM so that checkers
// can observe it.
module ps2_key_mapper #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       kb_clock,
  input  logic       kb_data,
  output logic [7:0] mapped_key,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [1:0] dbg_state,
  output logic [2:0] dbg_bit_cnt
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Synchronised and filtered line signals.
  logic          kbc_s1, kbc_s2, kbd_s1, kbd_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall_edge;

  // Receive FSM state and next-state values.
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic          good_frame, bad_frame;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  // Decoder state.
  logic          ext_flag, brk_flag;
  logic          key_hit;
  logic [2:0]    key_idx;

  // Two-flop synchronisers. They preset to 1, the idle level of the lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kbc_s1 <= 1'b1;
      kbc_s2 <= 1'b1;
      kbd_s1 <= 1'b1;
      kbd_s2 <= 1'b1;
    end else begin
      kbc_s1 <= kb_clock;
      kbc_s2 <= kbc_s1;
      kbd_s1 <= kb_data;
      kbd_s2 <= kbd_s1;
    end
  end

  // Clock filter: accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (kbc_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_clk <= kbc_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // An accepted falling edge occurs in the cycle where the filtered clock flips 1->0.
  assign fall_edge   = filt_clk & ~kbc_s2 & (filt_cnt == FILT_LAST);

  // An edge arriving in the same cycle takes priority over the timeout.
  assign timeout_hit = (state != IDLE) && !fall_edge && (to_cnt == TO_LAST);

  // Inter-edge timeout counter: it stays at zero while idle and restarts on every accepted edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state == IDLE || fall_edge || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Receive FSM registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par_bit <= par_n;
    end
  end

  // Receive FSM next state: one step per accepted falling edge, and an abort on timeout.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par_bit;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    if (timeout_hit) begin
      state_n   = IDLE;
      bad_frame = 1'b1;
    end else if (fall_edge) begin
      case (state)
        IDLE: begin
          // A high data bit here is a spurious edge, and the FSM ignores it.
          if (!kbd_s2) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          shift_n = {kbd_s2, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          par_n   = kbd_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (kbd_s2 && (^{shift, par_bit})) begin
            good_frame = 1'b1;
          end else begin
            bad_frame = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Frame result strobes and the last good byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      scan_code  <= '0;
    end else begin
      code_valid <= good_frame;
      frame_err  <= bad_frame;
      if (good_frame) begin
        scan_code <= shift;
      end
    end
  end

  // Scan-code lookup. The extended prefix selects the arrow-key table.
  always_comb begin
    key_hit = 1'b0;
    key_idx = 3'd0;
    if (ext_flag) begin
      case (scan_code)
        8'h75: begin key_hit = 1'b1; key_idx = 3'd0; end
        8'h72: begin key_hit = 1'b1; key_idx = 3'd1; end
        8'h6B: begin key_hit = 1'b1; key_idx = 3'd2; end
        8'h74: begin key_hit = 1'b1; key_idx = 3'd3; end
        default: ;
      endcase
    end else begin
      case (scan_code)
        8'h1D: begin key_hit = 1'b1; key_idx = 3'd0; end
        8'h1B: begin key_hit = 1'b1; key_idx = 3'd1; end
        8'h1C: begin key_hit = 1'b1; key_idx = 3'd2; end
        8'h23: begin key_hit = 1'b1; key_idx = 3'd3; end
        8'h5A: begin key_hit = 1'b1; key_idx = 3'd4; end
        8'h29: begin key_hit = 1'b1; key_idx = 3'd5; end
        8'h76: begin key_hit = 1'b1; key_idx = 3'd6; end
        default: ;
      endcase
    end
  end

  // Decoder: track the E0/F0 prefixes and apply make/break to the key levels.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      mapped_key <= '0;
    end else if (frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (code_valid) begin
      if (scan_code == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (scan_code == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        if (key_hit) begin
          mapped_key[key_idx] <= ~brk_flag;
        end
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  assign dbg_state   = state;
  assign dbg_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// tb_ps2_key_mapper: directed PS/2 frame stimulus with a queue-based scoreboard.
module tb_ps2_key_mapper;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 5000;
  localparam int HALF        = 20;

  logic       clk;
  logic       resetn;
  logic       kb_clock;
  logic       kb_data;
  logic [7:0] mapped_key;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic [1:0] dbg_state;
  logic [2:0] dbg_bit_cnt;

  int checks = 0;
  int errors = 0;

  // Expected events: {is_err, scan_code, mapped_key after the event}
  logic [16:0] exp_q[$];
  logic [7:0]  last_scan;
  logic [10:0] fb;

  ps2_key_mapper #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .kb_clock   (kb_clock),
    .kb_data    (kb_data),
    .mapped_key (mapped_key),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state),
    .dbg_bit_cnt(dbg_bit_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] data, input logic bad_par,
                                             input logic bad_stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = data;
    f[9]   = (~^data) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b);
    @(posedge clk);
    kb_data = b;
    repeat (HALF) @(posedge clk);
    kb_clock = 1'b0;
    repeat (HALF) @(posedge clk);
    kb_clock = 1'b1;
  endtask

  task automatic drive_range(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
  endtask

  task automatic gap();
    kb_data = 1'b1;
    repeat (60) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop,
                            input logic [7:0] exp_key);
    logic bad;
    bad = bad_par | bad_stop;
    if (!bad) last_scan = data;
    exp_q.push_back({bad, last_scan, exp_key});
    drive_range(make_frame(data, bad_par, bad_stop), 0, 10);
    gap();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (resetn && (code_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got valid=%0b err=%0b scan=0x%0h, expected none",
                   code_valid, frame_err, scan_code);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {30'd0, code_valid, frame_err}, {30'd0, ~e[16], e[16]});
          check("scan_code", {24'd0, scan_code}, {24'd0, e[15:8]});
          @(negedge clk);
          check("mapped_key", {24'd0, mapped_key}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn    = 1'b0;
    kb_clock  = 1'b1;
    kb_data   = 1'b1;
    last_scan = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mapped_key", {24'd0, mapped_key}, 32'h0);
    check("reset_scan_code", {24'd0, scan_code}, 32'h0);
    check("reset_strobes", {30'd0, code_valid, frame_err}, 32'h0);
    check("reset_state", {30'd0, dbg_state}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);

    // W make, then W break
    send_frame(8'h1D, 1'b0, 1'b0, 8'h01);
    send_frame(8'hF0, 1'b0, 1'b0, 8'h01);
    send_frame(8'h1D, 1'b0, 1'b0, 8'h00);

    // W make, arrow-up break shares the bit; then left arrow make/break
    send_frame(8'h1D, 1'b0, 1'b0, 8'h01);
    send_frame(8'hE0, 1'b0, 1'b0, 8'h01);
    send_frame(8'hF0, 1'b0, 1'b0, 8'h01);
    send_frame(8'h75, 1'b0, 1'b0, 8'h00);
    send_frame(8'hE0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h6B, 1'b0, 1'b0, 8'h04);
    send_frame(8'hE0, 1'b0, 1'b0, 8'h04);
    send_frame(8'hF0, 1'b0, 1'b0, 8'h04);
    send_frame(8'h6B, 1'b0, 1'b0, 8'h00);

    // Bad parity; the error also drops a pending E0, so 75 is unmapped
    send_frame(8'h5A, 1'b1, 1'b0, 8'h00);
    send_frame(8'hE0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h1B, 1'b1, 1'b0, 8'h00);
    send_frame(8'h75, 1'b0, 1'b0, 8'h00);
    send_frame(8'hAA, 1'b0, 1'b0, 8'h00);

    // Bad stop bit keeps the old scan_code; then space make/break
    send_frame(8'h29, 1'b0, 1'b1, 8'h00);
    send_frame(8'h29, 1'b0, 1'b0, 8'h20);
    send_frame(8'hF0, 1'b0, 1'b0, 8'h20);
    send_frame(8'h29, 1'b0, 1'b0, 8'h00);

    // Timeout after 5 bits
    exp_q.push_back({1'b1, last_scan, 8'h00});
    drive_range(make_frame(8'h5A, 1'b0, 1'b0), 0, 4);
    kb_data = 1'b1;
    repeat (TIMEOUT_CYC + 100) @(posedge clk);
    #1;
    check("timeout_state_idle", {30'd0, dbg_state}, 32'h0);
    check("timeout_event_seen", exp_q.size(), 32'h0);
    send_frame(8'h23, 1'b0, 1'b0, 8'h08);

    // Build mapped_key = 8'h11, then reset mid-frame
    send_frame(8'hF0, 1'b0, 1'b0, 8'h08);
    send_frame(8'h23, 1'b0, 1'b0, 8'h00);
    send_frame(8'h1D, 1'b0, 1'b0, 8'h01);
    send_frame(8'h5A, 1'b0, 1'b0, 8'h11);
    drive_range(make_frame(8'h76, 1'b0, 1'b0), 0, 5);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_mapped_key", {24'd0, mapped_key}, 32'h0);
    check("midreset_scan_code", {24'd0, scan_code}, 32'h0);
    check("midreset_state", {30'd0, dbg_state}, 32'h0);
    repeat (3) @(negedge clk);
    resetn    = 1'b1;
    last_scan = 8'h00;
    gap();
    send_frame(8'h76, 1'b0, 1'b0, 8'h40);

    // A glitch on kb_clock mid-frame must not sample a bit
    fb        = make_frame(8'h1C, 1'b0, 1'b0);
    last_scan = 8'h1C;
    exp_q.push_back({1'b0, 8'h1C, 8'h44});
    drive_range(fb, 0, 2);
    repeat (10) @(posedge clk);
    #1;
    check("pre_glitch_bit_cnt", {29'd0, dbg_bit_cnt}, 32'd2);
    check("pre_glitch_state", {30'd0, dbg_state}, 32'd1);
    @(posedge clk);
    kb_clock = 1'b0;
    repeat (3) @(posedge clk);
    kb_clock = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_glitch_bit_cnt", {29'd0, dbg_bit_cnt}, 32'd2);
    check("post_glitch_state", {30'd0, dbg_state}, 32'd1);
    drive_range(fb, 3, 10);
    gap();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
